mgmt_gpio_ctrl: RTL and testbench
=================================

# mgmt_gpio_ctrl

Register-mapped management GPIO controller for the SoC management core. It drives the single dedicated management `gpio` pad and a 16-bit check bank on user pads 31:16, where bits 7:0 are inputs and bits 15:8 are outputs. It also contains a hardware blink engine that emits N pulses on `gpio`. The controller sits between the management bus and the pad ring. Firmware uses it to report status to the off-chip test harness.

## Interface
- `HALF_PERIOD`, default 4: clock cycles per high or low phase of one blink pulse (≥1).
- `clock` in 1: single system clock; all logic on the rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `stb` in 1: bus request strobe; held until `ack`.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 5: byte address; bits 1:0 are ignored.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ack` = 1, otherwise 0.
- `ack` out 1: one-cycle acknowledge.
- `gpio_out` out 1: value driven to the mgmt `gpio` pad.
- `gpio_oe` out 1: output enable for the mgmt `gpio` pad.
- `gpio_in` in 1: pad input, asynchronous.
- `chk_out` out 8: drives pads 31:24 (check bank bits 15:8).
- `chk_oe` out 1: output enable for pads 31:24.
- `chk_in` in 8: pads 23:16 (check bank bits 7:0), asynchronous.

## Operation
- Register map (word addresses):
  - 0x00 GPIO, R/W: bit0 = out value, bit1 = oe. Reset 0.
  - 0x04 GPIO_IN, RO: bit0 = synchronized `gpio_in`.
  - 0x08 CHK_OUT, R/W: bits 7:0 drive `chk_out`; bit8 drives `chk_oe`. Reset 0.
  - 0x0C CHK_IN, RO: bits 7:0 = synchronized `chk_in`.
  - 0x10 BLINK, R/W. Write: bits 7:0 = pulse count N. Read: bits 7:0 = pulses remaining, bit8 = busy, bits 23:16 = total completed pulses since reset (wraps 255→0).
- Unused read bits are 0.
- Unmapped addresses: reads return 0, writes are ignored, and the access is still acknowledged.
- Both input paths use 2-flop synchronizers.
- Blink engine:
  - States are IDLE, HIGH and LOW.
  - Writing N>0 enters HIGH with remaining = N.
  - HIGH lasts HALF_PERIOD cycles, then moves to LOW.
  - LOW lasts HALF_PERIOD cycles, then decrements remaining and increments completed. If remaining is then 0 it goes to IDLE, otherwise to HIGH.
- While busy: `gpio_oe` = 1 and `gpio_out` = 1 in HIGH, 0 in LOW. The GPIO register is overridden but still writable, and its stored value takes effect when the engine reaches IDLE.
- Writing N while busy reloads remaining = N and restarts in HIGH with a fresh phase count.
- Writing 0 aborts immediately: the engine goes to IDLE and completed is unchanged.
- In IDLE: `gpio_out` = GPIO.bit0 and `gpio_oe` = GPIO.bit1.

## Timing
- `stb` sampled high with `ack` low gives `ack` = 1 on the next cycle, for exactly one cycle.
- A write commits on the same edge that raises `ack`, and its effect is visible at the outputs in that cycle.
- A request still held after `ack` starts a new access, giving an `ack` every second cycle at most.
- Input latency: a pad change is visible in GPIO_IN/CHK_IN 2 cycles later.
- Blink start: `gpio_out` rises in the cycle `ack` is asserted for the BLINK write.
- Blink length: exactly 2·HALF_PERIOD·N cycles until busy = 0.
- Reset (any time, including mid-blink) asynchronously sets the following to 0: all registers, `ack`, `rdata`, the synchronizers, remaining, completed, `gpio_out`, `gpio_oe`, `chk_out` and `chk_oe`. The engine goes to IDLE.

## Test plan
- Reset: hold `resetb` = 0 for 50 cycles → all outputs 0; reading BLINK gives 0.
- Write/readback:
  - Write GPIO = 0x3 → `gpio_out` = 1, `gpio_oe` = 1; read returns 0x3.
  - Write CHK_OUT = 0x1A5 → `chk_out` = 0xA5, `chk_oe` = 1.
  - Read 0x1C → 0 with `ack`.
- Input sync: set `chk_in` = 0x3C → CHK_IN reads 0x3C two or more cycles later. A read issued on the same cycle as the change returns the old value.
- Blink: with HALF_PERIOD = 4, write BLINK = 10.
  - Required: 10 rising edges on `gpio_out`, each high 4 cycles and low 4 cycles.
  - Busy clears 80 cycles after `ack`; BLINK reads completed = 10, remaining = 0.
  - `gpio_out` then returns to GPIO.bit0.
- Abort/restart:
  - Write BLINK = 5, then write BLINK = 0 after 2 pulses → busy = 0 immediately; completed = 2.
  - Write 3 mid-pulse → exactly 3 further full pulses follow.
- Reset mid-blink: assert `resetb` = 0 during HIGH → `gpio_out` = 0 immediately; after release, busy = 0 and completed = 0.

Source files
------------

// File: rtl/mgmt_gpio_ctrl.sv
// Management GPIO controller: register-mapped mgmt gpio pad, 16-bit check bank
// on user pads 31:16, and a hardware blink engine emitting N pulses on gpio.
module mgmt_gpio_ctrl #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        stb,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        gpio_out,
  output logic        gpio_oe,
  input  logic        gpio_in,
  output logic [7:0]  chk_out,
  output logic        chk_oe,
  input  logic [7:0]  chk_in
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} blink_state_t;

  localparam int unsigned   CW      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(HALF_PERIOD - 1);

  logic         r_ack;
  logic [31:0]  r_rdata;
  logic [1:0]   r_gpio;
  logic [8:0]   r_chk;
  logic [1:0]   r_gin_sync;
  logic [7:0]   r_cin_s1;
  logic [7:0]   r_cin_s2;
  blink_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_phase, w_phase_nxt;
  logic [7:0]   r_remain, w_remain_nxt;
  logic [7:0]   r_done, w_done_nxt;

  logic         w_access;
  logic         w_wr;
  logic         w_rd;
  logic         w_blink_wr;
  logic         w_busy;
  logic [2:0]   w_word;
  logic [31:0]  w_rmux;
  logic         w_unused;

  // A new access is accepted only while ack is low, so a held strobe
  // produces at most one ack every second cycle.
  assign w_access   = stb & ~r_ack;
  assign w_wr       = w_access & we;
  assign w_rd       = w_access & ~we;
  assign w_word     = addr[4:2];
  assign w_blink_wr = w_wr && (w_word == 3'd4);
  assign w_busy     = (r_state != ST_IDLE);
  assign w_unused   = &{1'b0, addr[1:0], wdata[31:9]};

  always_comb begin
    w_rmux = '0;
    case (w_word)
      3'd0:    w_rmux[1:0] = r_gpio;
      3'd1:    w_rmux[0]   = r_gin_sync[1];
      3'd2:    w_rmux[8:0] = r_chk;
      3'd3:    w_rmux[7:0] = r_cin_s2;
      3'd4:    w_rmux      = {8'h00, r_done, 7'h00, w_busy, r_remain};
      default: w_rmux      = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_gpio     <= '0;
      r_chk      <= '0;
      r_gin_sync <= '0;
      r_cin_s1   <= '0;
      r_cin_s2   <= '0;
    end else begin
      r_ack      <= w_access;
      r_rdata    <= w_rd ? w_rmux : '0;
      r_gin_sync <= {r_gin_sync[0], gpio_in};
      r_cin_s1   <= chk_in;
      r_cin_s2   <= r_cin_s1;
      if (w_wr) begin
        case (w_word)
          3'd0:    r_gpio <= wdata[1:0];
          3'd2:    r_chk  <= wdata[8:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_remain <= '0;
      r_done   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_remain <= w_remain_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // A BLINK write overrides the engine's own progress: N reloads and
  // restarts in HIGH, 0 aborts without crediting the partial pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_remain_nxt = r_remain;
    w_done_nxt   = r_done;
    if (w_blink_wr) begin
      w_phase_nxt  = '0;
      w_remain_nxt = wdata[7:0];
      w_state_nxt  = (wdata[7:0] == 8'd0) ? ST_IDLE : ST_HIGH;
    end else begin
      case (r_state)
        ST_HIGH: begin
          if (r_phase == PH_LAST) begin
            w_phase_nxt = '0;
            w_state_nxt = ST_LOW;
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        ST_LOW: begin
          if (r_phase == PH_LAST) begin
            w_phase_nxt  = '0;
            w_remain_nxt = r_remain - 8'd1;
            w_done_nxt   = r_done + 8'd1;
            w_state_nxt  = (r_remain == 8'd1) ? ST_IDLE : ST_HIGH;
          end else begin
            w_phase_nxt = r_phase + 1'b1;
          end
        end
        default: w_phase_nxt = '0;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign ack      = r_ack;
  assign gpio_out = w_busy ? (r_state == ST_HIGH) : r_gpio[0];
  assign gpio_oe  = w_busy | r_gpio[1];
  assign chk_out  = r_chk[7:0];
  assign chk_oe   = r_chk[8];

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Scoreboard bench for mgmt_gpio_ctrl: bus accesses push expected read data,
// a monitor pops and compares on every ack.
module tb_mgmt_gpio_ctrl;

  localparam int unsigned HP = 4;

  localparam logic [4:0] A_GPIO    = 5'h00;
  localparam logic [4:0] A_GPIO_IN = 5'h04;
  localparam logic [4:0] A_CHK_OUT = 5'h08;
  localparam logic [4:0] A_CHK_IN  = 5'h0C;
  localparam logic [4:0] A_BLINK   = 5'h10;

  logic        clock;
  logic        resetb;
  logic        stb;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        gpio_out;
  logic        gpio_oe;
  logic        gpio_in;
  logic [7:0]  chk_out;
  logic        chk_oe;
  logic [7:0]  chk_in;

  typedef struct {
    logic        is_wr;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t   sbq[$];
  string tagq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  mgmt_gpio_ctrl #(.HALF_PERIOD(HP)) dut (
    .clock    (clock),
    .resetb   (resetb),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .gpio_in  (gpio_in),
    .chk_out  (chk_out),
    .chk_oe   (chk_oe),
    .chk_in   (chk_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetb && ack) begin
      if (sbq.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        sb_t   e;
        string t;
        e = sbq.pop_front();
        t = tagq.pop_front();
        if (!e.is_wr) check(t, rdata & e.mask, e.exp & e.mask);
      end
    end
  end

  // Called at a negedge; returns at the negedge where ack is observed.
  task automatic bus(input string tag, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input logic [31:0] mask);
    logic got;
    sb_t  e;
    e.is_wr = w;
    e.exp   = exp;
    e.mask  = mask;
    sbq.push_back(e);
    tagq.push_back(tag);
    stb   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    got   = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if (ack) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
      if (sbq.size() != 0) begin
        void'(sbq.pop_back());
        void'(tagq.pop_back());
      end
    end
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    bus(tag, 1'b1, a, d, '0, '0);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp,
                    input logic [31:0] mask);
    bus(tag, 1'b0, a, '0, exp, mask);
  endtask

  // Starts on the cycle the blink write committed; samples through the first idle cycle.
  task automatic wave(input string tag, input int unsigned n, input logic idle_out,
                      input logic idle_oe);
    int unsigned lim;
    int unsigned bad;
    int unsigned falls;
    logic        prev;
    logic        exp_out;
    logic        exp_oe;
    lim   = 2 * HP * n;
    bad   = 0;
    falls = 0;
    prev  = 1'b0;
    for (int unsigned c = 0; c <= lim; c++) begin
      exp_out = (c < lim) ? ((c % (2 * HP)) < HP) : idle_out;
      exp_oe  = (c < lim) ? 1'b1 : idle_oe;
      if (gpio_out !== exp_out || gpio_oe !== exp_oe) bad++;
      if (prev && !gpio_out) falls++;
      prev = gpio_out;
      if (c < lim) @(negedge clock);
    end
    check({tag, "_shape_errs"}, bad, 32'd0);
    check({tag, "_pulses"}, falls, n);
  endtask

  initial begin
    resetb  = 1'b0;
    stb     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    gpio_in = 1'b0;
    chk_in  = '0;

    repeat (50) @(negedge clock);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst_chk_out", 32'(chk_out), 32'd0);
    check("rst_chk_oe", 32'(chk_oe), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    resetb = 1'b1;
    @(negedge clock);
    rd("rst_blink", A_BLINK, 32'h0, '1);

    wr("wr_gpio", A_GPIO, 32'h3);
    check("gpio_out_on_ack", 32'(gpio_out), 32'd1);
    check("gpio_oe_on_ack", 32'(gpio_oe), 32'd1);
    rd("rd_gpio", A_GPIO, 32'h3, '1);
    wr("wr_chk", A_CHK_OUT, 32'h1A5);
    check("chk_out_val", 32'(chk_out), 32'hA5);
    check("chk_oe_val", 32'(chk_oe), 32'd1);
    rd("rd_chk", A_CHK_OUT, 32'h1A5, '1);

    wr("wr_unmapped", 5'h14, 32'hFFFF_FFFF);
    check("unmapped_no_gpio", 32'({gpio_oe, gpio_out}), 32'h3);
    check("unmapped_no_chk", 32'({chk_oe, chk_out}), 32'h1A5);
    rd("rd_1c", 5'h1C, 32'h0, '1);
    rd("rd_14", 5'h14, 32'h0, '1);
    rd("rd_lowbits_ign", 5'h01, 32'h3, '1);

    gpio_in = 1'b1;
    repeat (3) @(negedge clock);
    rd("rd_gpio_in", A_GPIO_IN, 32'h1, '1);
    chk_in = 8'h3C;
    repeat (3) @(negedge clock);
    rd("rd_chk_in", A_CHK_IN, 32'h3C, '1);
    chk_in = 8'h5A;
    rd("rd_chk_in_old", A_CHK_IN, 32'h3C, '1);
    rd("rd_chk_in_new", A_CHK_IN, 32'h5A, '1);

    wr("wr_gpio0", A_GPIO, 32'h0);
    wr("wr_blink10", A_BLINK, 32'd10);
    wave("blink10", 10, 1'b0, 1'b0);
    rd("blink10_status", A_BLINK, 32'h000A_0000, '1);

    // Abort after two pulses; GPIO rewritten while overridden.
    wr("wr_blink5", A_BLINK, 32'd5);
    wr("wr_gpio_busy", A_GPIO, 32'h2);
    check("ovr_high_out", 32'(gpio_out), 32'd1);
    repeat (3) @(negedge clock);
    check("ovr_low_out", 32'(gpio_out), 32'd0);
    check("ovr_low_oe", 32'(gpio_oe), 32'd1);
    rd("busy_status", A_BLINK, 32'h000A_0105, '1);
    repeat (10) @(negedge clock);
    wr("wr_abort", A_BLINK, 32'd0);
    check("abort_out", 32'(gpio_out), 32'd0);
    check("abort_oe", 32'(gpio_oe), 32'd1);
    rd("abort_status", A_BLINK, 32'h000C_0000, 32'h00FF_0100);

    // Restart mid-pulse with N=3.
    wr("wr_blink5b", A_BLINK, 32'd5);
    repeat (2) @(negedge clock);
    wr("wr_restart3", A_BLINK, 32'd3);
    wave("restart3", 3, 1'b0, 1'b1);
    rd("restart_status", A_BLINK, 32'h000F_0000, '1);

    wr("wr_blink4", A_BLINK, 32'd4);
    @(negedge clock);
    check("pre_rst_high", 32'(gpio_out), 32'd1);
    resetb = 1'b0;
    #1;
    check("midrst_out", 32'(gpio_out), 32'd0);
    check("midrst_oe", 32'(gpio_oe), 32'd0);
    check("midrst_chk", 32'({chk_oe, chk_out}), 32'd0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    rd("post_rst_blink", A_BLINK, 32'h0, '1);
    rd("post_rst_gpio", A_GPIO, 32'h0, '1);
    check("post_rst_oe", 32'(gpio_oe), 32'd0);

    repeat (2) @(negedge clock);
    check("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
